fp_normalize_seq: RTL and testbench

FP_NORMALIZE_SEQ -- requirements
Module: fp_normalize_seq

---
 rtl/fp_normalize_seq.sv | 270 +++++++++++++++++++++++++++
 tb/tb_fp_normalize_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_normalize_seq.sv
// ---------------------------------------------------------------------------
// fp_normalize_seq
//   Sequential post-add normalizer for a floating-point adder. Takes the raw
//   sum of two aligned significands (carry, hidden, fraction, guard, sticky)
//   and produces a packed sign/exponent/fraction result. It normalizes right
//   by one on carry-out, or left by one bit per cycle, then rounds to nearest
//   even. The result is handed off with a valid/ready handshake.
//
// Ports
//   clk           : clock, all state changes on the rising edge
//   reset         : synchronous active-high reset
//   in_valid      : an unnormalized sum is presented
//   in_ready      : block is idle and will accept a sum
//   in_sign       : sign of the sum
//   in_exp        : biased exponent of the aligned operands
//   in_sum        : [MAN_W+3] carry, [MAN_W+2] hidden, [MAN_W+1:2] fraction,
//                   [1] guard, [0] sticky
//   out_valid     : packed result is present
//   out_ready     : consumer accepts the result
//   out_sign      : result sign
//   out_exp       : result biased exponent
//   out_frac      : result stored fraction (hidden bit dropped)
//   out_zero      : result is exactly zero
//   out_overflow  : result is infinity because the exponent saturated
// ---------------------------------------------------------------------------
module fp_normalize_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sign,
  input  logic [EXP_W-1:0]   in_exp,
  input  logic [MAN_W+3:0]   in_sum,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sign,
  output logic [EXP_W-1:0]   out_exp,
  output logic [MAN_W-1:0]   out_frac,
  output logic               out_zero,
  output logic               out_overflow
);

  localparam int SUM_W = MAN_W + 4;
  localparam int CNT_W = $clog2(MAN_W + 3);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Exponent math is carried one bit wider so an increment past all-ones is
  // visible instead of wrapping back to zero.
  localparam logic [EXP_W:0]   EXP_MAX   = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0]   EXP_ONE   = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [EXP_W:0]   EXP_ZERO  = {(EXP_W+1){1'b0}};
  localparam logic [CNT_W-1:0] SHIFT_MAX = CNT_W'(MAN_W + 2);

  // Round-to-nearest-even: round up when guard is set and either sticky or
  // the kept LSB is set (ties go to the even neighbour).
  function automatic logic rne_up(input logic lsb, input logic guard, input logic sticky);
    return guard & (sticky | lsb);
  endfunction

  logic [1:0]         r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_sign;
  logic [EXP_W:0]     r_exp;
  logic [SUM_W-1:0]   r_sum;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_out_sign;
  logic [EXP_W-1:0]   r_out_exp;
  logic [MAN_W-1:0]   r_out_frac;
  logic               r_out_zero;
  logic               r_out_ovf;

  logic [1:0]         w_state_nxt;
  logic               w_in_zero;
  logic [EXP_W:0]     w_in_exp_inc;
  logic               w_in_sat;
  logic [SUM_W-1:0]   w_in_shr;
  logic [SUM_W-1:0]   w_shl;
  logic [EXP_W:0]     w_exp_dec;
  logic               w_shift_lim;
  logic               w_denorm_stop;
  logic               w_rnd_inc;
  logic [MAN_W+1:0]   w_rnd;
  logic [EXP_W:0]     w_res_exp;
  logic [MAN_W-1:0]   w_res_frac;
  logic               w_res_ovf;

  assign w_in_zero    = (in_sum == {SUM_W{1'b0}});
  assign w_in_exp_inc = {1'b0, in_exp} + EXP_ONE;
  assign w_in_sat     = (w_in_exp_inc >= EXP_MAX);
  // Right shift on carry-out: the old guard folds into the new sticky.
  assign w_in_shr     = {1'b0, in_sum[SUM_W-1:2], in_sum[1] | in_sum[0]};
  // Left shift: sticky stays in place, guard is refilled with zero.
  assign w_shl        = {r_sum[SUM_W-2:1], 1'b0, r_sum[0]};
  assign w_exp_dec    = r_exp - EXP_ONE;
  // The shift budget stops a sticky-only sum from shifting forever.
  assign w_shift_lim  = (r_cnt == SHIFT_MAX);
  assign w_denorm_stop = (r_exp <= EXP_ONE);
  assign w_rnd_inc    = rne_up(r_sum[2], r_sum[1], r_sum[0]);
  // Bit MAN_W+1 of w_rnd is the rounding carry, bit MAN_W the hidden bit.
  assign w_rnd        = {1'b0, r_sum[SUM_W-2:2]} + {{(MAN_W+1){1'b0}}, w_rnd_inc};

  // Rounding result: exponent adjust for a rounding carry or a denormal
  // that rounded up into the hidden bit.
  always_comb begin
    w_res_exp  = r_exp;
    w_res_frac = w_rnd[MAN_W-1:0];
    if (w_rnd[MAN_W+1]) begin
      w_res_exp  = r_exp + EXP_ONE;
      w_res_frac = {MAN_W{1'b0}};
    end else if ((r_exp == EXP_ZERO) && w_rnd[MAN_W]) begin
      w_res_exp  = EXP_ONE;
    end else begin
      w_res_exp  = r_exp;
    end
    w_res_ovf = (w_res_exp >= EXP_MAX);
  end

  // Next-state decode of the normalize/round sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (w_in_zero) begin
            w_state_nxt = S_DONE;
          end else if (in_sum[SUM_W-1]) begin
            w_state_nxt = w_in_sat ? S_DONE : S_ROUND;
          end else if (in_sum[SUM_W-2]) begin
            w_state_nxt = S_ROUND;
          end else begin
            w_state_nxt = S_SHIFT;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (w_denorm_stop || w_shift_lim) begin
          w_state_nxt = S_ROUND;
        end else if (w_shl[SUM_W-2]) begin
          w_state_nxt = S_ROUND;
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_ROUND: w_state_nxt = S_DONE;
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, handshake flags, working registers and registered result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_sign      <= 1'b0;
      r_exp       <= EXP_ZERO;
      r_sum       <= {SUM_W{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_out_sign  <= 1'b0;
      r_out_exp   <= {EXP_W{1'b0}};
      r_out_frac  <= {MAN_W{1'b0}};
      r_out_zero  <= 1'b0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign <= in_sign;
            r_cnt  <= {CNT_W{1'b0}};
            if (w_in_zero) begin
              r_sum      <= {SUM_W{1'b0}};
              r_exp      <= EXP_ZERO;
              r_out_sign <= in_sign;
              r_out_exp  <= {EXP_W{1'b0}};
              r_out_frac <= {MAN_W{1'b0}};
              r_out_zero <= 1'b1;
              r_out_ovf  <= 1'b0;
            end else if (in_sum[SUM_W-1]) begin
              r_sum <= w_in_shr;
              r_exp <= w_in_exp_inc;
              if (w_in_sat) begin
                r_out_sign <= in_sign;
                r_out_exp  <= {EXP_W{1'b1}};
                r_out_frac <= {MAN_W{1'b0}};
                r_out_zero <= 1'b0;
                r_out_ovf  <= 1'b1;
              end else begin
                r_out_ovf  <= 1'b0;
              end
            end else begin
              r_sum <= in_sum;
              r_exp <= {1'b0, in_exp};
            end
          end else begin
            r_cnt <= r_cnt;
          end
        end
        S_SHIFT: begin
          if (w_denorm_stop) begin
            // Already at the minimum exponent: becomes a denormal unshifted.
            r_exp <= EXP_ZERO;
          end else if (w_shift_lim) begin
            r_exp <= r_exp;
          end else begin
            r_sum <= w_shl;
            r_exp <= w_exp_dec;
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        S_ROUND: begin
          r_out_sign <= r_sign;
          if (w_res_ovf) begin
            r_out_exp  <= {EXP_W{1'b1}};
            r_out_frac <= {MAN_W{1'b0}};
            r_out_zero <= 1'b0;
            r_out_ovf  <= 1'b1;
          end else begin
            r_out_exp  <= w_res_exp[EXP_W-1:0];
            r_out_frac <= w_res_frac;
            r_out_zero <= (w_res_exp == EXP_ZERO) && (w_res_frac == {MAN_W{1'b0}});
            r_out_ovf  <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_sign <= 1'b0;
            r_out_exp  <= {EXP_W{1'b0}};
            r_out_frac <= {MAN_W{1'b0}};
            r_out_zero <= 1'b0;
            r_out_ovf  <= 1'b0;
          end else begin
            r_out_ovf  <= r_out_ovf;
          end
        end
        default: begin
          r_sum <= {SUM_W{1'b0}};
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_sign     = r_out_sign;
  assign out_exp      = r_out_exp;
  assign out_frac     = r_out_frac;
  assign out_zero     = r_out_zero;
  assign out_overflow = r_out_ovf;

endmodule

// File: tb/tb_fp_normalize_seq.sv
// ---------------------------------------------------------------------------
// tb_fp_normalize_seq
//   Directed self-checking bench for fp_normalize_seq (EXP_W=8, MAN_W=23).
//   Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_fp_normalize_seq;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [MAN_W+3:0]  in_sum;
  logic              out_valid;
  logic              out_ready;
  logic              out_sign;
  logic [EXP_W-1:0]  out_exp;
  logic [MAN_W-1:0]  out_frac;
  logic              out_zero;
  logic              out_overflow;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_normalize_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_sum       (in_sum),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sign     (out_sign),
    .out_exp      (out_exp),
    .out_frac     (out_frac),
    .out_zero     (out_zero),
    .out_overflow (out_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic s, input logic [7:0] e, input logic [26:0] sum);
    @(negedge clk);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_sign  = s;
    in_exp   = e;
    in_sum   = sum;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Latency counts cycles after the accepting edge; 1 means the first cycle.
  task automatic expect_result(input string tag, input int lat, input logic s,
                               input logic [7:0] e, input logic [22:0] f,
                               input logic z, input logic o);
    int n;
    n = 1;
    @(negedge clk);
    while (out_valid !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_sign"}, {31'd0, out_sign}, {31'd0, s});
    chk({tag, "_exp"}, {24'd0, out_exp}, {24'd0, e});
    chk({tag, "_frac"}, {9'd0, out_frac}, {9'd0, f});
    chk({tag, "_zero"}, {31'd0, out_zero}, {31'd0, z});
    chk({tag, "_ovf"}, {31'd0, out_overflow}, {31'd0, o});
    chk({tag, "_in_ready_busy"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int hits;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 8'h00;
    in_sum    = 27'h0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_exp", {24'd0, out_exp}, 32'd0);
    chk("rst_out_frac", {9'd0, out_frac}, 32'd0);
    chk("rst_out_flags", {29'd0, out_sign, out_zero, out_overflow}, 32'd0);
    reset = 1'b0;

    // Already normalized, nothing to round.
    send(1'b0, 8'h7F, 27'h2000000);
    expect_result("norm", 2, 1'b0, 8'h7F, 23'h0, 1'b0, 1'b0);
    accept("norm");

    // Carry-out: right shift and exponent increment.
    send(1'b0, 8'h80, 27'h6000000);
    expect_result("carry", 2, 1'b0, 8'h81, 23'h400000, 1'b0, 1'b0);
    accept("carry");

    // Two left shifts.
    send(1'b0, 8'h7F, 27'h0800000);
    expect_result("shift2", 4, 1'b0, 8'h7D, 23'h0, 1'b0, 1'b0);
    accept("shift2");

    // All-ones fraction with guard: rounding carries into the exponent.
    send(1'b0, 8'h7F, 27'h3FFFFFE);
    expect_result("rnd_carry", 2, 1'b0, 8'h80, 23'h0, 1'b0, 1'b0);
    accept("rnd_carry");

    // Carry at exponent 0xFE saturates to infinity straight from capture.
    send(1'b0, 8'hFE, 27'h4000000);
    expect_result("ovf", 1, 1'b0, 8'hFF, 23'h0, 1'b0, 1'b1);
    accept("ovf");

    // Exact tie with even LSB stays down.
    send(1'b1, 8'h10, 27'h2000002);
    expect_result("tie_even", 2, 1'b1, 8'h10, 23'h0, 1'b0, 1'b0);
    accept("tie_even");

    // Exact tie with odd LSB rounds up to even.
    send(1'b0, 8'h10, 27'h2000006);
    expect_result("tie_odd", 2, 1'b0, 8'h10, 23'h2, 1'b0, 1'b0);
    accept("tie_odd");

    // Above half (guard + sticky) rounds up.
    send(1'b0, 8'h10, 27'h2000003);
    expect_result("above_half", 2, 1'b0, 8'h10, 23'h1, 1'b0, 1'b0);
    accept("above_half");

    // Exponent 1 with hidden clear becomes a denormal without shifting.
    send(1'b0, 8'h01, 27'h0800000);
    expect_result("denorm", 3, 1'b0, 8'h00, 23'h200000, 1'b0, 1'b0);
    accept("denorm");

    // Zero sum keeps its sign; then back-pressure for three cycles.
    send(1'b1, 8'h55, 27'h0);
    expect_result("zero", 1, 1'b1, 8'h00, 23'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_flags", {29'd0, out_sign, out_zero, out_overflow}, 32'd6);
      chk("hold_exp", {24'd0, out_exp}, 32'd0);
      chk("hold_frac", {9'd0, out_frac}, 32'd0);
    end
    accept("zero");

    // Reset in the middle of a long left-shift run aborts it.
    send(1'b0, 8'h7F, 27'h0000800);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    hits = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) hits++;
    end
    chk("abort_no_valid", hits, 32'd0);

    // Reset wins over a same-cycle in_valid.
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_sign  = 1'b0;
    in_sum   = 27'h0;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rstprio_valid", {31'd0, out_valid}, 32'd0);
    chk("rstprio_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk("rstprio_valid2", {31'd0, out_valid}, 32'd0);

    // Normal operation resumes after the aborts.
    send(1'b1, 8'h40, 27'h2000000);
    expect_result("resume", 2, 1'b1, 8'h40, 23'h0, 1'b0, 1'b0);
    accept("resume");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
